// File: rtl/instr_fetch_unit.sv
// Program sequencer: owns the PC, drives the instruction ROM address, holds the IR,
// resolves conditional jumps and detects program end / PC overrun.
module instr_fetch_unit #(
    parameter int ADDR_W     = 10,
    parameter int INSTR_W    = 16,
    parameter int OPC_W      = 6,
    parameter int JUMPZ_OPC  = 52,
    parameter int JUMPNZ_OPC = 47,
    parameter int HALT_OPC   = 46,
    parameter int PROG_LEN   = 165
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     z_flag,
    input  logic                     exec_done,
    output logic                     instr_valid,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] operand,
    output logic                     running,
    output logic                     halted,
    output logic                     fault,
    output logic [15:0]              retired
);

    // state | meaning
    // IDLE  | waiting for start, pc held at 0
    // FETCH | imem_addr stable, ROM registers the word
    // LOAD  | ROM word captured into IR
    // EXEC  | instruction presented, waiting for exec_done
    // HALT  | program ended (HALT opcode or overrun fault)

    localparam int OPR_W = INSTR_W - OPC_W;
    localparam int NPC_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [15:0]         retired_q;
    logic                instr_valid_q;
    logic                running_q;
    logic                halted_q;
    logic                fault_q;

    logic [OPC_W-1:0]    opc_w;
    logic [OPR_W-1:0]    opr_w;
    logic [NPC_W-1:0]    next_pc_d;
    logic                overrun_d;
    logic [15:0]         retired_d;

    assign opc_w = ir_q[INSTR_W-1 -: OPC_W];
    assign opr_w = ir_q[OPR_W-1:0];

    // One extra bit so pc+1 wrapping past the address space still reads as overrun.
    always_comb begin
        next_pc_d = NPC_W'(pc_q) + NPC_W'(1);
        if ((opc_w == OPC_W'(JUMPZ_OPC)) && z_flag)
            next_pc_d = NPC_W'(opr_w);
        else if ((opc_w == OPC_W'(JUMPNZ_OPC)) && !z_flag)
            next_pc_d = NPC_W'(opr_w);
        overrun_d = (next_pc_d >= NPC_W'(PROG_LEN));
        retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            retired_q     <= '0;
            instr_valid_q <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pc_q <= '0;
                    if (start) begin
                        state_q   <= S_FETCH;
                        running_q <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    ir_q          <= imem_data;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid_q <= 1'b0;
                        retired_q     <= retired_d;
                        if (opc_w == OPC_W'(HALT_OPC)) begin
                            state_q   <= S_HALT;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else if (overrun_d) begin
                            state_q   <= S_HALT;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                            fault_q   <= 1'b1;
                        end else begin
                            pc_q    <= next_pc_d[ADDR_W-1:0];
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_q      <= '0;
                        fault_q   <= 1'b0;
                        retired_q <= '0;
                        halted_q  <= 1'b0;
                        running_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign opcode      = opc_w;
    assign operand     = opr_w;
    assign instr_valid = instr_valid_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program sequencer directly downstream of the instruction ROM. It owns the program counter and drives the ROM address. It captures each 16-bit instruction word ({opcode[15:10], operand[9:0]}) into an instruction register and presents the opcode and operand to the datapath control unit. It resolves JUMPZ/JUMPNZ, detects program end and overrun, and counts retired instructions.

Parameters:
ADDR_W, 10, PC and ROM address width (matches the 10-bit jump operand)
INSTR_W, 16, instruction word width
OPC_W, 6, opcode field width (instruction bits [15:10])
JUMPZ_OPC, 52, opcode of jump-if-zero
JUMPNZ_OPC, 47, opcode of jump-if-not-zero
HALT_OPC, 46, opcode that ends the program (NOP at program end)
PROG_LEN, 165, number of valid ROM words; a PC at or above this value is a fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution at address 0
imem_addr  out  ADDR_W  ROM address (registered, always equals pc)
imem_data  in  INSTR_W  ROM read data, valid one clock after imem_addr changes
z_flag  in  1  accumulator-zero flag from the datapath
exec_done  in  1  datapath has finished the current instruction
instr_valid  out  1  opcode/operand valid, execution in progress
opcode  out  OPC_W  IR[15:10]
operand  out  10  IR[9:0] (immediate data or jump target)
running  out  1  high in FETCH, LOAD and EXEC
halted  out  1  high in HALT
fault  out  1  PC overran PROG_LEN
retired  out  16  count of completed instructions, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE. pc, imem_addr, IR, opcode, operand, retired = 0. instr_valid, running, halted, fault = 0.
- States: IDLE, FETCH, LOAD, EXEC, HALT. All transitions occur on the rising edge of clk.
- IDLE: pc held at 0. When start=1 → FETCH.
- FETCH: imem_addr=pc is stable, and the ROM registers the word at the end of this cycle → LOAD.
- LOAD: IR<=imem_data at the end of the cycle → EXEC.
- EXEC: instr_valid=1, with opcode and operand driven from IR. EXEC holds until exec_done=1. On exec_done:
  - retired increments, saturating.
  - If opcode==HALT_OPC → HALT. pc is unchanged.
  - Otherwise next_pc is computed:
    - opcode==JUMPZ_OPC and z_flag=1 → next_pc=operand.
    - opcode==JUMPNZ_OPC and z_flag=0 → next_pc=operand.
    - Any other case → next_pc=pc+1.
  - z_flag is sampled in the same cycle as exec_done.
  - If next_pc >= PROG_LEN → HALT with fault=1, and pc is left unchanged. Otherwise pc<=next_pc and the state goes to FETCH.
- instr_valid stays high through the exec_done cycle and is low from the next cycle.
- Minimum period is 3 cycles per instruction (FETCH, LOAD, EXEC), with exec_done tied high. First instr_valid appears 3 cycles after the edge that samples start.
- imem_addr is registered. It is updated together with pc, so it is never glitching and never changes during LOAD.
- HALT: halted=1 and running=0, and opcode/operand hold their last values. When start=1: pc=0, fault=0, retired=0 → FETCH.
- start is ignored in FETCH, LOAD and EXEC. exec_done and z_flag are ignored outside EXEC.
- Jump operands wider than the ROM depth are caught by the PROG_LEN check and never sent to the ROM.
- Reset asserted mid-instruction aborts immediately, with no retire and no pc update.

Test Plan:
1. ROM model holding the convolution program; reset; pulse start at edge k → imem_addr=0 in cycle k+1, instr_valid=1 with opcode=0 in cycle k+3. With exec_done tied high, imem_addr=1 by cycle k+4.
2. pc=143, IR={52,10'd159}, z_flag=1 with exec_done → next imem_addr=159. Repeat with z_flag=0 → 144.
3. pc=163, IR={47,10'd63}, z_flag=0 → imem_addr=63. With z_flag=1 → 164, then the NOP at 164 → halted=1, running=0, fault=0, and retired equals the number of exec_done pulses.
4. Overrun: PROG_LEN=4, ROM with no halt opcode, exec_done high → after 4 retires, fault=1, halted=1, imem_addr=3.
5. exec_done delayed 5 cycles in EXEC → instr_valid held for 5 cycles, pc/imem_addr stable, retired increments once. Pulses of start and exec_done outside their valid states have no effect.
6. Assert rst_n=0 mid-EXEC → all outputs 0 asynchronously, before the next clock edge. Release, pulse start → fetch restarts at address 0. A start pulse in HALT clears fault and retired.
